// File: rtl/wd_fault_logger.sv
// Watchdog fault logger: edge-detects watchdog fault and reset requests, timestamps fault
// events into a first-word-fall-through log, keeps saturating counters and a sticky
// safe-state request.
// Optional build macro WD_LOG_BROWNOUT_EN: brownout rising edges become logged events
// (code 3'b111), with a one-entry pending register for collisions with a WDFAIL event.
module wd_fault_logger #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned SAFE_LIMIT = 4,
  parameter int unsigned TS_WIDTH   = 12
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WDFAIL,
  input  logic [2:0]  FLSTAT,
  input  logic        RSTOUT,
  input  logic        BROWNOUT,
  input  logic        POP,
  input  logic        CLR,
  output logic [15:0] DOUT,
  output logic        EMPTY,
  output logic        FULL,
  output logic        OVF,
  output logic [7:0]  FLTCNT,
  output logic [3:0]  RSTCNT,
  output logic        SAFE
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam logic [7:0]  SafeLim  = SAFE_LIMIT[7:0];
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  // Free-running timestamp and edge-detect history
  logic [TS_WIDTH-1:0] ts_q;
  logic                wdfail_q;
  logic                rstout_q;

  // Log storage and bookkeeping
  logic [15:0]         mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          fltcnt_q, fltcnt_d;
  logic [3:0]          rstcnt_q, rstcnt_d;
  logic                safe_q, safe_d;

  logic                fault_evt;
  logic                rst_evt;
  logic                wr_req;
  logic [15:0]         wr_data;
  logic [1:0]          flt_inc;
  logic                pop_ok;
  logic                wr_ok;
  logic                mem_we;
  logic [8:0]          flt_sum;

  assign fault_evt = WDFAIL & ~wdfail_q;
  assign rst_evt   = RSTOUT & ~rstout_q;

`ifdef WD_LOG_BROWNOUT_EN
  logic brown_q;
  logic pend_q, pend_d;
  logic brown_evt;

  assign brown_evt = BROWNOUT & ~brown_q;

  // Pick the entry to write this cycle: WDFAIL first, then a parked brownout, then a new one
  always_comb begin
    wr_req  = fault_evt | pend_q | brown_evt;
    wr_data = {3'b111, 1'b1, ts_q[11:0]};
    if (fault_evt) begin
      wr_data = {FLSTAT, BROWNOUT, ts_q[11:0]};
    end
    // A brownout loses the slot to a WDFAIL event, or to an older parked brownout
    pend_d  = fault_evt ? (pend_q | brown_evt) : (pend_q & brown_evt);
    if (CLR) begin
      pend_d = 1'b0;
    end
    flt_inc = {1'b0, fault_evt} + {1'b0, brown_evt};
  end

  // Brownout edge history and pending-entry register
  always_ff @(posedge CLK) begin
    if (RST) begin
      brown_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      brown_q <= BROWNOUT;
      pend_q  <= pend_d;
    end
  end
`else
  // Only WDFAIL edges create entries; BROWNOUT is merely recorded in bit 12
  always_comb begin
    wr_req  = fault_evt;
    wr_data = {FLSTAT, BROWNOUT, ts_q[11:0]};
    flt_inc = {1'b0, fault_evt};
  end
`endif

  assign EMPTY  = (cnt_q == '0);
  assign FULL   = (cnt_q == CntFull);
  assign OVF    = ovf_q;
  assign FLTCNT = fltcnt_q;
  assign RSTCNT = rstcnt_q;
  assign SAFE   = safe_q;

  assign pop_ok  = POP & ~EMPTY;
  // A write into a full log only fits if the head leaves in the same cycle
  assign wr_ok   = wr_req & (~FULL | pop_ok);
  assign mem_we  = wr_ok & ~CLR;
  assign flt_sum = {1'b0, fltcnt_q} + {7'd0, flt_inc};

  // Head entry falls through from storage; masked to zero while empty
  always_comb begin
    DOUT = 16'h0000;
    if (!EMPTY) begin
      DOUT = mem_q[rd_ptr_q];
    end
  end

  // Next-state for pointers, occupancy, flags and counters
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    fltcnt_d = flt_sum[8] ? 8'hFF : flt_sum[7:0];
    rstcnt_d = rstcnt_q;
    safe_d   = safe_q | (fltcnt_q >= SafeLim);

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({wr_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (wr_req && !wr_ok) begin
      ovf_d = 1'b1;
    end
    if (rst_evt && (rstcnt_q != 4'hF)) begin
      rstcnt_d = rstcnt_q + 4'd1;
    end

    // Clear wins over anything else happening this cycle
    if (CLR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      fltcnt_d = 8'h00;
      rstcnt_d = 4'h0;
      safe_d   = 1'b0;
    end
  end

  // Timestamp counter; only reset clears it
  always_ff @(posedge CLK) begin
    if (RST) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_WIDTH'(1);
    end
  end

  // Control state; edge history keeps tracking inputs even during CLR
  always_ff @(posedge CLK) begin
    if (RST) begin
      wdfail_q <= 1'b0;
      rstout_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      fltcnt_q <= 8'h00;
      rstcnt_q <= 4'h0;
      safe_q   <= 1'b0;
    end else begin
      wdfail_q <= WDFAIL;
      rstout_q <= RSTOUT;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      fltcnt_q <= fltcnt_d;
      rstcnt_q <= rstcnt_d;
      safe_q   <= safe_d;
    end
  end

  // Log storage; stale contents are harmless since DOUT is masked when empty
  always_ff @(posedge CLK) begin
    if (!RST && mem_we) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_wd_fault_logger.sv
// Scoreboard bench for wd_fault_logger: stimulus pushes expected log entries, a negedge
// monitor pops and compares whenever a POP consumes a non-empty head.
`timescale 1ns/1ps
module tb_wd_fault_logger;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WDFAIL = 1'b0;
  logic [2:0]  FLSTAT = 3'b000;
  logic        RSTOUT = 1'b0;
  logic        BROWNOUT = 1'b0;
  logic        POP = 1'b0;
  logic        CLR = 1'b0;
  logic [15:0] DOUT;
  logic        EMPTY;
  logic        FULL;
  logic        OVF;
  logic [7:0]  FLTCNT;
  logic [3:0]  RSTCNT;
  logic        SAFE;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [11:0] tb_ts = 12'h000;

`ifdef WD_LOG_BROWNOUT_EN
  localparam int NBrown = 1;
`else
  localparam int NBrown = 0;
`endif

  wd_fault_logger #(
    .DEPTH      (8),
    .SAFE_LIMIT (4),
    .TS_WIDTH   (12)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WDFAIL   (WDFAIL),
    .FLSTAT   (FLSTAT),
    .RSTOUT   (RSTOUT),
    .BROWNOUT (BROWNOUT),
    .POP      (POP),
    .CLR      (CLR),
    .DOUT     (DOUT),
    .EMPTY    (EMPTY),
    .FULL     (FULL),
    .OVF      (OVF),
    .FLTCNT   (FLTCNT),
    .RSTCNT   (RSTCNT),
    .SAFE     (SAFE)
  );

  always #5 CLK = ~CLK;

  // Reference timestamp: cleared only by reset
  always @(posedge CLK) tb_ts <= RST ? 12'h000 : tb_ts + 12'h001;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One WDFAIL pulse (event edge plus re-arm edge); optionally expect it in the log
  task automatic ev(input logic [2:0] code, input bit expect_entry);
    WDFAIL = 1'b1;
    FLSTAT = code;
    if (expect_entry) exp_q.push_back({code, BROWNOUT, tb_ts});
    cyc(1);
    WDFAIL = 1'b0;
    cyc(1);
  endtask

  // Monitor: every consumed head entry must match the scoreboard
  always @(negedge CLK) begin
    if (POP && (EMPTY === 1'b0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_extra: got %h expected no entry", DOUT);
      end else begin
        check("pop_data", DOUT, exp_q.pop_front());
      end
    end
  end

  initial begin
    cyc(2);
    RST = 1'b0;
    check("rst_empty", 16'(EMPTY), 16'h0001);
    check("rst_full", 16'(FULL), 16'h0000);
    check("rst_ovf", 16'(OVF), 16'h0000);
    check("rst_fltcnt", 16'(FLTCNT), 16'h0000);
    check("rst_rstcnt", 16'(RSTCNT), 16'h0000);
    check("rst_safe", 16'(SAFE), 16'h0000);
    check("rst_dout", DOUT, 16'h0000);

    // First event captured with timestamp 0x005
    cyc(5);
    WDFAIL = 1'b1;
    FLSTAT = 3'b011;
    exp_q.push_back(16'h6005);
    cyc(1);
    check("first_dout", DOUT, 16'h6005);
    check("first_empty", 16'(EMPTY), 16'h0000);
    check("first_fltcnt", 16'(FLTCNT), 16'h0001);

    // Level held: one event only; re-arm after one low cycle
    cyc(19);
    check("held_fltcnt", 16'(FLTCNT), 16'h0001);
    WDFAIL = 1'b0;
    cyc(1);
    WDFAIL = 1'b1;
    FLSTAT = 3'b101;
    exp_q.push_back({3'b101, 1'b0, tb_ts});
    cyc(1);
    check("rearm_fltcnt", 16'(FLTCNT), 16'h0002);
    WDFAIL = 1'b0;
    POP = 1'b1;
    cyc(2);
    POP = 1'b0;
    check("drain_empty", 16'(EMPTY), 16'h0001);
    check("drain_dout", DOUT, 16'h0000);

    // POP while empty is ignored
    POP = 1'b1;
    cyc(1);
    POP = 1'b0;
    check("pop_empty_empty", 16'(EMPTY), 16'h0001);
    check("pop_empty_fltcnt", 16'(FLTCNT), 16'h0002);

    // RSTOUT edge counting and saturation
    RSTOUT = 1'b1;
    cyc(3);
    check("rstcnt_1", 16'(RSTCNT), 16'h0001);
    RSTOUT = 1'b0;
    cyc(1);
    RSTOUT = 1'b1;
    cyc(1);
    check("rstcnt_2", 16'(RSTCNT), 16'h0002);
    for (int i = 0; i < 20; i++) begin
      RSTOUT = 1'b0;
      cyc(1);
      RSTOUT = 1'b1;
      cyc(1);
    end
    RSTOUT = 1'b0;
    check("rstcnt_sat", 16'(RSTCNT), 16'h000F);

    CLR = 1'b1;
    cyc(1);
    CLR = 1'b0;
    check("clr_fltcnt", 16'(FLTCNT), 16'h0000);
    check("clr_rstcnt", 16'(RSTCNT), 16'h0000);
    check("clr_empty", 16'(EMPTY), 16'h0001);

    // Nine events into eight entries, no POP
    for (int i = 0; i < 9; i++) begin
      ev(3'(i), i < 8);
      if (i == 2) check("safe_before", 16'(SAFE), 16'h0000);
      if (i == 3) check("safe_after4", 16'(SAFE), 16'h0001);
      if (i == 7) begin
        check("full_8", 16'(FULL), 16'h0001);
        check("ovf_8", 16'(OVF), 16'h0000);
      end
    end
    check("ovf_9", 16'(OVF), 16'h0001);
    check("fltcnt_9", 16'(FLTCNT), 16'h0009);
    check("safe_9", 16'(SAFE), 16'h0001);
    POP = 1'b1;
    cyc(8);
    POP = 1'b0;
    check("pop8_empty", 16'(EMPTY), 16'h0001);
    check("pop8_dout", DOUT, 16'h0000);
    check("pop8_ovf_sticky", 16'(OVF), 16'h0001);

    CLR = 1'b1;
    cyc(1);
    CLR = 1'b0;
    check("clr2_ovf", 16'(OVF), 16'h0000);
    check("clr2_safe", 16'(SAFE), 16'h0000);

    // Full log: event and POP in the same cycle
    for (int i = 0; i < 8; i++) ev(3'(i), 1'b1);
    check("fill_full", 16'(FULL), 16'h0001);
    WDFAIL = 1'b1;
    FLSTAT = 3'b111;
    POP = 1'b1;
    exp_q.push_back({3'b111, 1'b0, tb_ts});
    cyc(1);
    WDFAIL = 1'b0;
    POP = 1'b0;
    check("evpop_full", 16'(FULL), 16'h0001);
    check("evpop_ovf", 16'(OVF), 16'h0000);
    cyc(1);
    POP = 1'b1;
    cyc(8);
    POP = 1'b0;
    check("evpop_drain_empty", 16'(EMPTY), 16'h0001);

    // CLR coincident with a WDFAIL edge
    ev(3'd1, 1'b0);
    check("preclr_empty", 16'(EMPTY), 16'h0000);
    WDFAIL = 1'b1;
    FLSTAT = 3'b010;
    CLR = 1'b1;
    cyc(1);
    CLR = 1'b0;
    check("clrev_empty", 16'(EMPTY), 16'h0001);
    check("clrev_fltcnt", 16'(FLTCNT), 16'h0000);
    check("clrev_safe", 16'(SAFE), 16'h0000);
    cyc(2);
    check("clrev_noevent", 16'(EMPTY), 16'h0001);
    WDFAIL = 1'b0;
    cyc(1);
    ev(3'd6, 1'b1);
    check("postclr_fltcnt", 16'(FLTCNT), 16'h0001);
    POP = 1'b1;
    cyc(1);
    POP = 1'b0;

    // WDFAIL and BROWNOUT rising together
    BROWNOUT = 1'b1;
    WDFAIL = 1'b1;
    FLSTAT = 3'b010;
    exp_q.push_back({3'b010, 1'b1, tb_ts});
    if (NBrown == 1) exp_q.push_back({3'b111, 1'b1, tb_ts + 12'h001});
    cyc(1);
    WDFAIL = 1'b0;
    cyc(1);
    check("brown_fltcnt", 16'(FLTCNT), 16'(2 + NBrown));
    BROWNOUT = 1'b0;
    POP = 1'b1;
    cyc(1 + NBrown);
    POP = 1'b0;
    check("brown_empty", 16'(EMPTY), 16'h0001);

    // RST mid-operation, with WDFAIL already high as reset releases
    ev(3'd4, 1'b0);
    WDFAIL = 1'b1;
    FLSTAT = 3'b100;
    RST = 1'b1;
    cyc(1);
    check("midrst_empty", 16'(EMPTY), 16'h0001);
    check("midrst_fltcnt", 16'(FLTCNT), 16'h0000);
    check("midrst_dout", DOUT, 16'h0000);
    RST = 1'b0;
    exp_q.push_back(16'h8000);
    cyc(1);
    check("postrst_empty", 16'(EMPTY), 16'h0000);
    check("postrst_fltcnt", 16'(FLTCNT), 16'h0001);
    WDFAIL = 1'b0;
    POP = 1'b1;
    cyc(1);
    POP = 1'b0;

    // Bounded drain of any outstanding expectations
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding entries expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
